rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter with grant hold, release handshake and hold-time watchdog. It produces a registered 2-bit grant index plus a valid flag; the index drives the existing 2-to-4 one-hot decoder, which expands it into per-requester enables (e.g. shared write-port or bus-select lines). The block owns all fairness and ownership timing so that the decoder stage stays purely combinational.

---
 rtl/rr_arbiter4_if.sv | 22 ++
 rtl/rr_arbiter4.sv | 98 +++++++++
 tb/tb_rr_arbiter4.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The owner's "finished" strobe is called owner_done because "release" is a
// reserved word in SystemVerilog.
interface rr_arbiter4_if;
  logic [3:0] req;         // bit i = requester i, level-sensitive
  logic       owner_done;  // current owner finished; only looked at while granted
  logic [1:0] grant_idx;   // registered owner index, feeds the 2-to-4 decoder
  logic       grant_valid; // grant_idx is meaningful only while high
  logic       timeout;     // one-cycle pulse: grant force-ended by the watchdog

  // Requester side.
  modport master (
    output req, owner_done,
    input  grant_idx, grant_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, owner_done,
    output grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold, release handshake and
// hold-time watchdog. Every output is a flop, so the downstream one-hot
// decoder sees no combinational path from req or owner_done.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15  // max grant length in cycles, 0 disables the watchdog (0..255)
) (
  input  logic          CLK,
  input  logic          Reset_L,
  rr_arbiter4_if.slave  bus
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Counter value seen on the final permitted grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       grant_idx;
  logic             grant_valid;
  logic             timeout;
  logic [1:0]       last;      // most recent owner; the scan starts just after it
  logic [CNT_W-1:0] hold_cnt;  // completed grant cycles, saturating

  logic [1:0] winner;
  logic       end_release;
  logic       end_withdraw;
  logic       end_watchdog;
  logic       grant_end;

  // Round-robin pick: first set request scanning last+1, last+2, last+3, last.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it an all-zero req would infer a latch.
    winner = last;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int off = 4; off >= 1; off--) begin
      if (bus.req[2'(last + 2'(off))]) winner = last + 2'(off);
    end
  end

  // Grant-end causes, evaluated against the current owner.
  always_comb begin
    end_release  = bus.owner_done;
    end_withdraw = ~bus.req[grant_idx];
    end_watchdog = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    grant_end    = end_release | end_withdraw | end_watchdog;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge CLK or negedge Reset_L) begin
    // NOTE: every register here is a control flop (no memory array), so all
    // of them take the asynchronous reset; last=3 makes requester 0 first.
    if (!Reset_L) begin
      state       <= IDLE;
      grant_idx   <= 2'b00;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      last        <= 2'b11;
      hold_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values (e.g. last <= grant_idx uses the old owner).
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            // grant_idx is left alone so the decoder input stays stable.
            last        <= grant_idx;
            grant_valid <= 1'b0;
            state       <= IDLE;
            timeout     <= end_watchdog & ~end_release & ~end_withdraw;
          end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = grant_valid;
  assign bus.timeout     = timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a per-cycle vector table on a MAX_HOLD=4
// instance, then hand-written sequences for asynchronous reset and for the
// disabled watchdog on a MAX_HOLD=0 instance.
module tb_rr_arbiter4;

  logic CLK     = 1'b0;
  logic Reset_L = 1'b0;

  always #5 CLK = ~CLK;

  rr_arbiter4_if bus ();
  rr_arbiter4_if bus0 ();

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  rr_arbiter4 #(.MAX_HOLD(0)) u_dut0 (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus0)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       valid;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic done,
                     input logic valid, input logic [1:0] idx, input logic to);
    vec_t v;
    v.req = req; v.done = done; v.valid = valid; v.idx = idx; v.to = to;
    vecs.push_back(v);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.req  = 4'b0000; bus.owner_done  = 1'b0;
    bus0.req = 4'b0000; bus0.owner_done = 1'b0;

    // Expected outputs after the edge on which each row's inputs are sampled.
    //  req      done  valid idx  to
    // Full request, release one cycle after each grant: 0,1,2,3,0 with gaps.
    add(4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    add(4'b1111, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 2'd1, 1'b0);
    add(4'b1111, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 2'd2, 1'b0);
    add(4'b1111, 1'b0, 1'b1, 2'd3, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 2'd3, 1'b0);
    add(4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    // Release while idle does nothing.
    add(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    // Single requester 2, then 0101 must wrap to 0 (scan 3,0,...).
    add(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
    add(4'b0101, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'b0101, 1'b1, 1'b0, 2'd0, 1'b0);
    // Owner 2 withdraws; successor among {0,3} after 2 is 3.
    add(4'b0101, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'b0001, 1'b0, 1'b0, 2'd2, 1'b0);
    add(4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    // Release on the 4th grant cycle coincides with the watchdog: no timeout.
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b1, 1'b0, 2'd1, 1'b0);
    // Watchdog alone: 4 grant cycles, timeout pulse, regrant after one gap.
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b1, 1'b0, 2'd1, 1'b0);
    // Withdraw on the watchdog cycle: no timeout either.
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

    // Reset state while Reset_L is held low.
    #12;
    check("reset valid", {7'd0, bus.grant_valid}, 8'd0);
    check("reset idx",   {6'd0, bus.grant_idx},   8'd0);
    check("reset to",    {7'd0, bus.timeout},     8'd0);
    @(negedge CLK);
    Reset_L = 1'b1;

    foreach (vecs[i]) begin
      bus.req        = vecs[i].req;
      bus.owner_done = vecs[i].done;
      step();
      check($sformatf("vec%0d valid", i), {7'd0, bus.grant_valid}, {7'd0, vecs[i].valid});
      check($sformatf("vec%0d idx", i),   {6'd0, bus.grant_idx},   {6'd0, vecs[i].idx});
      check($sformatf("vec%0d to", i),    {7'd0, bus.timeout},     {7'd0, vecs[i].to});
    end

    // Async reset mid-grant. last is 1 here, so 0100 grants 2.
    bus.req = 4'b0100; bus.owner_done = 1'b0;
    step();
    check("pre-rst valid", {7'd0, bus.grant_valid}, 8'd1);
    check("pre-rst idx",   {6'd0, bus.grant_idx},   8'd2);
    #3 Reset_L = 1'b0;
    #1;
    check("async rst valid", {7'd0, bus.grant_valid}, 8'd0);
    check("async rst to",    {7'd0, bus.timeout},     8'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    // last must be back at 3: 1001 grants 0 (a stale last=1 would give 3).
    bus.req = 4'b1001;
    step();
    check("post-rst 1001 valid", {7'd0, bus.grant_valid}, 8'd1);
    check("post-rst 1001 idx",   {6'd0, bus.grant_idx},   8'd0);
    bus.owner_done = 1'b1;
    step();
    check("post-rst release", {7'd0, bus.grant_valid}, 8'd0);
    bus.owner_done = 1'b0; bus.req = 4'b1000;
    step();
    check("post-rst 1000 idx", {6'd0, bus.grant_idx}, 8'd3);
    bus.owner_done = 1'b1;
    step();
    bus.owner_done = 1'b0;

    // Async reset while the timeout pulse is high.
    bus.req = 4'b0001;
    repeat (4) step();
    check("wd hold valid", {7'd0, bus.grant_valid}, 8'd1);
    step();
    check("wd pulse", {7'd0, bus.timeout}, 8'd1);
    #3 Reset_L = 1'b0;
    #1;
    check("async rst clears to", {7'd0, bus.timeout}, 8'd0);
    bus.req = 4'b0000;
    @(negedge CLK);
    Reset_L = 1'b1;

    // Watchdog disabled: a held request keeps its grant indefinitely.
    bus0.req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("nowd c%0d valid", c), {7'd0, bus0.grant_valid}, 8'd1);
      check($sformatf("nowd c%0d to", c),    {7'd0, bus0.timeout},     8'd0);
    end
    bus0.req = 4'b0000;
    step();
    check("nowd withdraw", {7'd0, bus0.grant_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
